// File: rtl/sequence_checker.sv
// Monitor for the 3-bit TFF sequence generator (legal cycle 0->1->3->5->7->0).
// Hunts for a run of correct transitions, locks, then flags and counts deviations.
module sequence_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_MISS = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             seq_valid_i,
  input  logic [2:0]       seq_in_i,
  input  logic             clr_err_i,
  output logic             locked_o,
  output logic             exp_valid_o,
  output logic [2:0]       expected_o,
  output logic             err_pulse_o,
  output logic             wrap_pulse_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_MISS + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             exp_valid_q, exp_valid_d;
  logic [2:0]       expected_q, expected_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  function automatic logic [2:0] nxt(input logic [2:0] v);
    logic [2:0] r;
    case (v)
      3'd0:    r = 3'd1;
      3'd1:    r = 3'd3;
      3'd3:    r = 3'd5;
      3'd5:    r = 3'd7;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // 2, 4 and 6 are the stuck states of the generator
  function automatic logic is_legal(input logic [2:0] v);
    return (v != 3'd2) && (v != 3'd4) && (v != 3'd6);
  endfunction

  logic legal, cmp, hit, miss, good_last, miss_last;

  always_comb begin
    legal     = is_legal(seq_in_i);
    cmp       = seq_valid_i && legal && exp_valid_q;
    hit       = cmp && (seq_in_i == expected_q);
    miss      = seq_valid_i && (!legal || (cmp && !hit));
    good_last = (good_cnt_q == GW'(LOCK_CNT - 1));
    miss_last = (miss_cnt_q == MW'(UNLOCK_MISS - 1));
  end

  // State register
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:   if (hit && good_last) state_d = LOCKED;
      LOCKED: if (miss && miss_last) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // Output and counter next-state logic
  always_comb begin
    good_cnt_d   = good_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    exp_valid_d  = exp_valid_q;
    expected_d   = expected_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_count_d  = err_count_q;

    if (seq_valid_i) begin
      if (legal) begin
        expected_d  = nxt(seq_in_i);
        exp_valid_d = 1'b1;
      end else begin
        exp_valid_d = 1'b0;
        good_cnt_d  = '0;
      end

      unique case (state_q)
        HUNT: begin
          if (hit) begin
            if (good_last) begin
              good_cnt_d = GW'(LOCK_CNT);
              miss_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end else if (cmp) begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_cnt_d   = '0;
            wrap_pulse_d = (seq_in_i == 3'd0);
          end else if (miss) begin
            err_pulse_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (miss_last) begin
              miss_cnt_d = '0;
              good_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // A clear request beats a same-edge increment
    if (clr_err_i) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      good_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      exp_valid_q  <= 1'b0;
      expected_q   <= 3'd0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      good_cnt_q   <= good_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      exp_valid_q  <= exp_valid_d;
      expected_q   <= expected_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked_o     = (state_q == LOCKED);
  assign exp_valid_o  = exp_valid_q;
  assign expected_o   = expected_q;
  assign err_pulse_o  = err_pulse_q;
  assign wrap_pulse_o = wrap_pulse_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: a reference model pushes expected outputs per edge,
// a negedge monitor pops and compares; scenario tasks add directed checks.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       clear_i = 1'b1;
  logic       seq_valid_i = 1'b0;
  logic [2:0] seq_in_i = 3'd0;
  logic       clr_err_i = 1'b0;
  logic       locked_o, exp_valid_o, err_pulse_o, wrap_pulse_o;
  logic [2:0] expected_o;
  logic [7:0] err_count_o;

  int errors = 0;
  int checks = 0;

  sequence_checker #(.LOCK_CNT(4), .UNLOCK_MISS(2), .CNT_W(8)) dut (
    .clk_i(clk), .clear_i(clear_i), .seq_valid_i(seq_valid_i), .seq_in_i(seq_in_i),
    .clr_err_i(clr_err_i), .locked_o(locked_o), .exp_valid_o(exp_valid_o),
    .expected_o(expected_o), .err_pulse_o(err_pulse_o), .wrap_pulse_o(wrap_pulse_o),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       locked;
    logic       ev;
    logic [2:0] exp;
    logic       ep;
    logic       wp;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic       m_locked, m_ev;
  logic [2:0] m_exp;
  int         m_cnt, m_good, m_miss;
  logic       m_ep, m_wp;

  function automatic logic [2:0] succ(input logic [2:0] v);
    logic [2:0] tbl [8];
    tbl = '{3'd1, 3'd3, 3'd0, 3'd5, 3'd0, 3'd7, 3'd0, 3'd0};
    return tbl[v];
  endfunction

  task automatic model_reset();
    m_locked = 0; m_ev = 0; m_exp = 0; m_cnt = 0; m_good = 0; m_miss = 0;
    m_ep = 0; m_wp = 0;
  endtask

  task automatic model_miss();
    m_ep = 1;
    if (m_cnt < 255) m_cnt++;
    m_miss++;
    if (m_miss == 2) begin
      m_locked = 0; m_good = 0; m_miss = 0;
    end
  endtask

  task automatic model_edge(input logic v, input logic [2:0] s, input logic clr);
    logic ok, same;
    m_ep = 0; m_wp = 0;
    if (v) begin
      ok = !(s == 3'd2 || s == 3'd4 || s == 3'd6);
      if (!ok) begin
        m_ev = 0; m_good = 0;
        if (m_locked) model_miss();
      end else if (!m_ev) begin
        m_exp = succ(s); m_ev = 1;
      end else begin
        same = (s == m_exp);
        m_exp = succ(s);
        if (m_locked) begin
          if (same) begin
            m_miss = 0;
            if (s == 3'd0) m_wp = 1;
          end else model_miss();
        end else if (same) begin
          m_good++;
          if (m_good == 4) begin m_locked = 1; m_miss = 0; end
        end else m_good = 0;
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic step(input logic v, input logic [2:0] s, input logic clr);
    exp_t e;
    seq_valid_i = v; seq_in_i = s; clr_err_i = clr;
    model_edge(v, s, clr);
    e.locked = m_locked; e.ev = m_ev; e.exp = m_exp;
    e.ep = m_ep; e.wp = m_wp; e.cnt = 8'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk); #1;
    seq_valid_i = 0; clr_err_i = 0;
  endtask

  task automatic do_clear();
    @(negedge clk); #1;
    clear_i = 1; #1; clear_i = 0;
    model_reset();
  endtask

  task automatic lock_up();
    step(1, 3'd0, 0); step(1, 3'd1, 0); step(1, 3'd3, 0);
    step(1, 3'd5, 0); step(1, 3'd7, 0);
  endtask

  // Scoreboard monitor, away from the active edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e, g;
      e = sb_q.pop_front();
      g = {locked_o, exp_valid_o, expected_o, err_pulse_o, wrap_pulse_o, err_count_o};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got locked=%b ev=%b exp=%0d ep=%b wp=%b cnt=%0d, want locked=%b ev=%b exp=%0d ep=%b wp=%b cnt=%0d",
                 $time, g.locked, g.ev, g.exp, g.ep, g.wp, g.cnt,
                 e.locked, e.ev, e.exp, e.ep, e.wp, e.cnt);
      end
    end
  end

  task automatic test_reset();
    #2;
    checks++;
    if ({locked_o, exp_valid_o, expected_o, err_pulse_o, wrap_pulse_o, err_count_o} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {locked_o, exp_valid_o, expected_o, err_pulse_o, wrap_pulse_o, err_count_o});
    end
    @(negedge clk); #1;
    clear_i = 0;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_lock();
    step(1, 3'd0, 0); step(1, 3'd1, 0); step(1, 3'd3, 0); step(1, 3'd5, 0);
    checks++;
    if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_early: got %b, want 0", locked_o); end
    step(1, 3'd7, 0);
    checks++;
    if (locked_o !== 1'b1) begin errors++; $display("FAIL lock_on_7: got %b, want 1", locked_o); end
    checks++;
    if (err_count_o !== 8'd0) begin errors++; $display("FAIL lock_cnt: got %0d, want 0", err_count_o); end
    $display("test_lock done");
  endtask

  task automatic test_wrap();
    step(1, 3'd0, 0);
    checks++;
    if ({wrap_pulse_o, exp_valid_o, expected_o} !== {1'b1, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL wrap: got wp=%b ev=%b exp=%0d, want wp=1 ev=1 exp=1", wrap_pulse_o, exp_valid_o, expected_o);
    end
    step(0, 3'd5, 0);
    checks++;
    if (wrap_pulse_o !== 1'b0) begin errors++; $display("FAIL wrap_len: got %b, want 0", wrap_pulse_o); end
    $display("test_wrap done");
  endtask

  task automatic test_unlock();
    step(1, 3'd1, 0); step(1, 3'd3, 0); step(1, 3'd4, 0);
    checks++;
    if ({err_pulse_o, locked_o, err_count_o} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL unlock_first4: got ep=%b locked=%b cnt=%0d, want 1 1 1", err_pulse_o, locked_o, err_count_o);
    end
    step(1, 3'd4, 0);
    checks++;
    if ({err_pulse_o, locked_o, err_count_o} !== {1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL unlock_second4: got ep=%b locked=%b cnt=%0d, want 1 0 2", err_pulse_o, locked_o, err_count_o);
    end
    $display("test_unlock done");
  endtask

  task automatic test_single_miss();
    do_clear();
    lock_up();
    step(1, 3'd0, 0); step(1, 3'd1, 0); step(1, 3'd5, 0); step(1, 3'd7, 0);
    checks++;
    if ({locked_o, err_count_o} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL single_miss: got locked=%b cnt=%0d, want 1 1", locked_o, err_count_o);
    end
    // A second isolated miss must not unlock if the 5->7 match cleared the run
    step(1, 3'd3, 0);
    checks++;
    if ({locked_o, err_count_o} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL miss_cleared: got locked=%b cnt=%0d, want 1 2", locked_o, err_count_o);
    end
    $display("test_single_miss done");
  endtask

  task automatic test_saturate();
    do_clear();
    lock_up();
    for (int i = 0; i < 256; i++) begin
      step(1, succ(m_exp), 0);
      step(1, m_exp, 0);
    end
    checks++;
    if ({locked_o, err_count_o} !== {1'b1, 8'd255}) begin
      errors++;
      $display("FAIL saturate: got locked=%b cnt=%0d, want 1 255", locked_o, err_count_o);
    end
    step(1, succ(m_exp), 1);
    checks++;
    if ({err_pulse_o, err_count_o} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL clr_wins: got ep=%b cnt=%0d, want 1 0", err_pulse_o, err_count_o);
    end
    $display("test_saturate done");
  endtask

  task automatic test_mid_clear();
    do_clear();
    lock_up();
    step(1, 3'd0, 0); step(1, 3'd1, 0); step(1, 3'd2, 0);
    @(negedge clk); #1;
    clear_i = 1; #1;
    checks++;
    if ({locked_o, exp_valid_o, expected_o, err_pulse_o, wrap_pulse_o, err_count_o} !== 14'd0) begin
      errors++;
      $display("FAIL mid_clear: got %b, want all zero",
               {locked_o, exp_valid_o, expected_o, err_pulse_o, wrap_pulse_o, err_count_o});
    end
    clear_i = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 3'(i + 1), 0);
    checks++;
    if ({locked_o, exp_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL idle_hold: got locked=%b ev=%b, want 0 0", locked_o, exp_valid_o);
    end
    step(1, 3'd0, 0); step(1, 3'd1, 0); step(1, 3'd3, 0); step(1, 3'd5, 0);
    checks++;
    if (locked_o !== 1'b0) begin errors++; $display("FAIL relock_early: got %b, want 0", locked_o); end
    step(1, 3'd7, 0);
    checks++;
    if (locked_o !== 1'b1) begin errors++; $display("FAIL relock: got %b, want 1", locked_o); end
    $display("test_mid_clear done");
  endtask

  task automatic test_random();
    logic       v;
    logic [2:0] s;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) < 7) ? succ(m_exp) : 3'($urandom_range(0, 7));
      if (!m_ev && $urandom_range(0, 1) == 1) s = 3'd0;
      step(v, s, ($urandom_range(0, 31) == 0));
    end
    $display("test_random done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_unlock();
    test_single_miss();
    test_saturate();
    test_mid_clear();
    test_random();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
